// File: rtl/ram_port_arbiter.sv
// Arbitrates the single synchronous RAM port between the stack unit, the CPU
// load/store path and a read-only DMA burst engine; RAM command outputs are registered.
module ram_port_arbiter #(
    parameter int unsigned MAX_BURST    = 8,
    parameter int unsigned STARVE_LIMIT = 15
) (
    input  logic        clk,
    input  logic        rst,

    input  logic        stk_req,
    input  logic        stk_w,
    input  logic [15:0] stk_addr,
    input  logic [15:0] stk_wdata,
    output logic        stk_gnt,
    output logic        stk_rvalid,

    input  logic        cpu_req,
    input  logic        cpu_w,
    input  logic [15:0] cpu_addr,
    input  logic [15:0] cpu_wdata,
    output logic        cpu_gnt,
    output logic        cpu_rvalid,

    input  logic        dma_req,
    input  logic [15:0] dma_addr,
    input  logic [3:0]  dma_len,
    output logic        dma_gnt,
    output logic        dma_rvalid,
    output logic        dma_done,

    input  logic [15:0] fromRAM,
    output logic [15:0] rdata,
    output logic [15:0] RAMaddr,
    output logic [15:0] toRAM,
    output logic        w
);

    localparam int unsigned CNT_W = $clog2(STARVE_LIMIT + 1);

    typedef enum logic {
        IDLE,
        BURST
    } state_t;

    typedef enum logic [1:0] {
        OWN_NONE,
        OWN_STK,
        OWN_CPU,
        OWN_DMA
    } owner_t;

    state_t           state;
    logic [15:0]      burst_addr;
    logic [3:0]       burst_left;
    logic [CNT_W-1:0] starve_cnt;

    owner_t           owner_q1;
    owner_t           owner_q2;
    logic             last_q1;
    logic             last_q2;

    logic             cpu_starved;
    logic [3:0]       dma_eff_len;
    logic             dma_issue;

    logic             cmd_v;
    logic             cmd_w;
    logic [15:0]      cmd_addr;
    logic [15:0]      cmd_wdata;
    owner_t           cmd_own;
    logic             cmd_last;

    assign cpu_starved = (starve_cnt == CNT_W'(STARVE_LIMIT));

    always_comb begin
        if (dma_len == 4'd0 || 32'(dma_len) > MAX_BURST)
            dma_eff_len = 4'(MAX_BURST);
        else
            dma_eff_len = dma_len;
    end

    // Grants are combinational; gating with rst keeps every grant low during reset.
    always_comb begin
        stk_gnt   = 1'b0;
        cpu_gnt   = 1'b0;
        dma_gnt   = 1'b0;
        dma_issue = 1'b0;
        if (rst) begin
            if (stk_req)
                stk_gnt = 1'b1;
            else if (state == BURST)
                dma_issue = 1'b1;
            else if (cpu_req && cpu_starved)
                cpu_gnt = 1'b1;
            else if (dma_req)
                dma_gnt = 1'b1;
            else if (cpu_req)
                cpu_gnt = 1'b1;
        end
    end

    always_comb begin
        cmd_v     = 1'b0;
        cmd_w     = 1'b0;
        cmd_addr  = '0;
        cmd_wdata = '0;
        cmd_own   = OWN_NONE;
        cmd_last  = 1'b0;
        if (stk_gnt) begin
            cmd_v     = 1'b1;
            cmd_w     = stk_w;
            cmd_addr  = stk_addr;
            cmd_wdata = stk_wdata;
            cmd_own   = stk_w ? OWN_NONE : OWN_STK;
        end else if (cpu_gnt) begin
            cmd_v     = 1'b1;
            cmd_w     = cpu_w;
            cmd_addr  = cpu_addr;
            cmd_wdata = cpu_wdata;
            cmd_own   = cpu_w ? OWN_NONE : OWN_CPU;
        end else if (dma_gnt) begin
            cmd_v     = 1'b1;
            cmd_addr  = dma_addr;
            cmd_own   = OWN_DMA;
            cmd_last  = (dma_eff_len == 4'd1);
        end else if (dma_issue) begin
            cmd_v     = 1'b1;
            cmd_addr  = burst_addr;
            cmd_own   = OWN_DMA;
            cmd_last  = (burst_left == 4'd1);
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state      <= IDLE;
            burst_addr <= '0;
            burst_left <= '0;
            starve_cnt <= '0;
            RAMaddr    <= '0;
            toRAM      <= '0;
            w          <= 1'b0;
            owner_q1   <= OWN_NONE;
            owner_q2   <= OWN_NONE;
            last_q1    <= 1'b0;
            last_q2    <= 1'b0;
        end else begin
            if (cmd_v)
                RAMaddr <= cmd_addr;
            w     <= cmd_v && cmd_w;
            toRAM <= (cmd_v && cmd_w) ? cmd_wdata : '0;

            owner_q1 <= cmd_own;
            last_q1  <= cmd_last;
            owner_q2 <= owner_q1;
            last_q2  <= last_q1;

            if (cpu_req && !cpu_gnt) begin
                if (!cpu_starved)
                    starve_cnt <= starve_cnt + CNT_W'(1);
            end else begin
                starve_cnt <= '0;
            end

            // Word 0 goes out with the grant, so the burst registers track word 1 onward.
            case (state)
                IDLE: begin
                    if (dma_gnt) begin
                        burst_addr <= dma_addr + 16'd1;
                        burst_left <= dma_eff_len - 4'd1;
                        if (dma_eff_len != 4'd1)
                            state <= BURST;
                    end
                end
                BURST: begin
                    if (dma_issue) begin
                        burst_addr <= burst_addr + 16'd1;
                        burst_left <= burst_left - 4'd1;
                        if (burst_left == 4'd1)
                            state <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign stk_rvalid = (owner_q2 == OWN_STK);
    assign cpu_rvalid = (owner_q2 == OWN_CPU);
    assign dma_rvalid = (owner_q2 == OWN_DMA);
    assign dma_done   = (owner_q2 == OWN_DMA) && last_q2;
    assign rdata      = fromRAM;

endmodule

// File: tb/tb_ram_port_arbiter.sv
// Randomized bench for ram_port_arbiter: a queue-based transaction model predicts
// grants, RAM commands and read returns each cycle, alongside a RAM behavioural model.
module tb_ram_port_arbiter;

    localparam int MAX_BURST    = 8;
    localparam int STARVE_LIMIT = 15;

    logic        clk = 1'b0;
    logic        rst;
    logic        stk_req, stk_w, cpu_req, cpu_w, dma_req;
    logic [15:0] stk_addr, stk_wdata, cpu_addr, cpu_wdata, dma_addr;
    logic [3:0]  dma_len;
    logic        stk_gnt, stk_rvalid, cpu_gnt, cpu_rvalid;
    logic        dma_gnt, dma_rvalid, dma_done;
    logic [15:0] fromRAM, rdata, RAMaddr, toRAM;
    logic        w;

    ram_port_arbiter #(
        .MAX_BURST   (MAX_BURST),
        .STARVE_LIMIT(STARVE_LIMIT)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .stk_req   (stk_req),
        .stk_w     (stk_w),
        .stk_addr  (stk_addr),
        .stk_wdata (stk_wdata),
        .stk_gnt   (stk_gnt),
        .stk_rvalid(stk_rvalid),
        .cpu_req   (cpu_req),
        .cpu_w     (cpu_w),
        .cpu_addr  (cpu_addr),
        .cpu_wdata (cpu_wdata),
        .cpu_gnt   (cpu_gnt),
        .cpu_rvalid(cpu_rvalid),
        .dma_req   (dma_req),
        .dma_addr  (dma_addr),
        .dma_len   (dma_len),
        .dma_gnt   (dma_gnt),
        .dma_rvalid(dma_rvalid),
        .dma_done  (dma_done),
        .fromRAM   (fromRAM),
        .rdata     (rdata),
        .RAMaddr   (RAMaddr),
        .toRAM     (toRAM),
        .w         (w)
    );

    always #5 clk = ~clk;

    function automatic logic [15:0] init_val(input logic [15:0] a);
        return (a * 16'h9E37) ^ 16'h5A5A;
    endfunction

    // Synchronous RAM: data for the address presented in cycle t appears in t+1.
    logic [15:0] ram    [0:65535];
    bit          ram_wr [0:65535];
    always @(posedge clk) begin
        if (w) begin
            ram[RAMaddr]    <= toRAM;
            ram_wr[RAMaddr] <= 1'b1;
        end
        fromRAM <= ram_wr[RAMaddr] ? ram[RAMaddr] : init_val(RAMaddr);
    end

    int n_cmp = 0;
    int n_err = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
        end
    endtask

    // Reference model state
    logic [15:0] model_mem [0:65535];
    logic [15:0] burst_q[$];
    int          denied;
    logic        e_v, e_w;
    logic [15:0] e_wd, e_addr;
    int          e1_own, e2_own;
    logic        e1_last, e2_last;
    logic [15:0] e1_data, e2_data;
    logic        gs, gc, gd;
    logic        obs_cpu_gnt;

    task automatic model_reset();
        burst_q.delete();
        denied = 0;
        e_v = 1'b0; e_w = 1'b0; e_wd = '0; e_addr = '0;
        e1_own = 0; e2_own = 0; e1_last = 1'b0; e2_last = 1'b0;
        e1_data = '0; e2_data = '0;
        gs = 1'b0; gc = 1'b0; gd = 1'b0;
    endtask

    task automatic clear_reqs();
        stk_req = 1'b0; cpu_req = 1'b0; dma_req = 1'b0;
        stk_w = 1'b0; cpu_w = 1'b0;
    endtask

    // One clock cycle: check outputs at negedge, predict this cycle's grant, advance model.
    task automatic step();
        logic [15:0] a, wd;
        logic        cv, cw, last;
        int          own, n;
        @(negedge clk);
        chk("w", 32'(w), 32'(e_v && e_w));
        chk("RAMaddr", 32'(RAMaddr), 32'(e_addr));
        if (!(e_v && !e_w))
            chk("toRAM", 32'(toRAM), (e_v && e_w) ? 32'(e_wd) : 32'd0);
        chk("rvalid", {28'd0, stk_rvalid, cpu_rvalid, dma_rvalid, dma_done},
            {28'd0, e2_own == 1, e2_own == 2, e2_own == 3, e2_own == 3 && e2_last});
        if (e2_own != 0)
            chk("rdata", 32'(rdata), 32'(e2_data));

        gs = 1'b0; gc = 1'b0; gd = 1'b0;
        cv = 1'b0; cw = 1'b0; a = e_addr; wd = '0; own = 0; last = 1'b0;
        if (stk_req) begin
            gs = 1'b1; cv = 1'b1; a = stk_addr; cw = stk_w; wd = stk_wdata;
            own = stk_w ? 0 : 1;
        end else if (burst_q.size() > 0) begin
            cv = 1'b1; a = burst_q.pop_front(); own = 3;
            last = (burst_q.size() == 0);
        end else if (cpu_req && (denied >= STARVE_LIMIT || !dma_req)) begin
            gc = 1'b1; cv = 1'b1; a = cpu_addr; cw = cpu_w; wd = cpu_wdata;
            own = cpu_w ? 0 : 2;
        end else if (dma_req) begin
            n = (dma_len == 0 || int'(dma_len) > MAX_BURST) ? MAX_BURST : int'(dma_len);
            for (int i = 0; i < n; i++)
                burst_q.push_back(dma_addr + 16'(i));
            gd = 1'b1; cv = 1'b1; a = burst_q.pop_front(); own = 3;
            last = (burst_q.size() == 0);
        end
        chk("gnt", {29'd0, stk_gnt, cpu_gnt, dma_gnt}, {29'd0, gs, gc, gd});
        obs_cpu_gnt = cpu_gnt;

        e2_own = e1_own; e2_last = e1_last; e2_data = e1_data;
        e1_own = own; e1_last = last; e1_data = model_mem[a];
        if (cv && cw)
            model_mem[a] = wd;
        e_v = cv; e_w = cw; e_wd = wd;
        if (cv)
            e_addr = a;
        if (cpu_req && !gc)
            denied = (denied < STARVE_LIMIT) ? denied + 1 : denied;
        else
            denied = 0;
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input int n);
        clear_reqs();
        for (int i = 0; i < n; i++)
            step();
    endtask

    // Requesters hold until granted, then may drop or issue a fresh request.
    task automatic drive_random();
        if (!stk_req || gs) begin
            stk_req   = ($urandom_range(0, 99) < 12);
            stk_w     = 1'($urandom_range(0, 1));
            stk_addr  = 16'($urandom_range(0, 31));
            stk_wdata = 16'($urandom);
        end
        if (!cpu_req || gc) begin
            cpu_req   = ($urandom_range(0, 99) < 45);
            cpu_w     = 1'($urandom_range(0, 1));
            cpu_addr  = 16'($urandom_range(0, 31));
            cpu_wdata = 16'($urandom);
        end
        if (!dma_req || gd) begin
            dma_req  = ($urandom_range(0, 99) < 35);
            dma_addr = ($urandom_range(0, 3) == 0) ? 16'(16'hFFF8 + $urandom_range(0, 7))
                                                   : 16'($urandom_range(0, 31));
            dma_len  = 4'($urandom);
        end
    endtask

    int first_cpu;

    initial begin
        for (int i = 0; i < 65536; i++)
            model_mem[i] = init_val(16'(i));
        model_reset();
        clear_reqs();
        stk_addr = '0; stk_wdata = '0; cpu_addr = '0; cpu_wdata = '0;
        dma_addr = '0; dma_len = '0;

        // Reset state, with requests pending to confirm grants are held off
        rst = 1'b0;
        stk_req = 1'b1; cpu_req = 1'b1; dma_req = 1'b1;
        #3;
        chk("reset_data", {RAMaddr, toRAM}, 32'd0);
        chk("reset_ctl", {24'd0, w, stk_gnt, cpu_gnt, dma_gnt, stk_rvalid, cpu_rvalid,
                          dma_rvalid, dma_done}, 32'd0);
        clear_reqs();
        @(posedge clk);
        @(posedge clk);
        #1;
        rst = 1'b1;
        idle(2);

        // CPU write then read back
        cpu_req = 1'b1; cpu_w = 1'b1; cpu_addr = 16'h0010; cpu_wdata = 16'h1234;
        step();
        idle(1);
        cpu_req = 1'b1; cpu_w = 1'b0; cpu_addr = 16'h0010;
        step();
        idle(4);

        // Wrapping 4-word burst
        dma_req = 1'b1; dma_addr = 16'hFFFE; dma_len = 4'd4;
        step();
        idle(7);

        // 8-word burst with a one-cycle stack preemption at word 3
        dma_req = 1'b1; dma_addr = 16'h0100; dma_len = 4'd8;
        step();
        idle(2);
        stk_req = 1'b1; stk_w = 1'b0; stk_addr = 16'h0003;
        step();
        idle(10);

        // All three at once, then DMA held with CPU waiting until starved
        stk_req = 1'b1; stk_w = 1'b1; stk_addr = 16'h0007; stk_wdata = 16'hBEEF;
        dma_req = 1'b1; dma_addr = 16'h2000; dma_len = 4'd8;
        cpu_req = 1'b1; cpu_w = 1'b0; cpu_addr = 16'h0007;
        step();
        stk_req = 1'b0;
        first_cpu = -1;
        for (int i = 0; i < 40; i++) begin
            step();
            if (obs_cpu_gnt && first_cpu < 0)
                first_cpu = i;
        end
        // Stack takes cycle 0; bursts occupy 0..7 and 8..15, CPU starved by cycle 16
        chk("starve_first_cpu", 32'(first_cpu), 32'd16);
        idle(12);

        // Length edge cases
        dma_req = 1'b1; dma_addr = 16'h0300; dma_len = 4'd0;
        step();
        idle(10);
        dma_req = 1'b1; dma_addr = 16'h0400; dma_len = 4'd1;
        step();
        cpu_req = 1'b1; cpu_w = 1'b0; cpu_addr = 16'h0010;
        step();
        idle(4);
        dma_req = 1'b1; dma_addr = 16'h0500; dma_len = 4'd13;
        step();
        idle(10);

        // Reset during word 2 of a burst
        dma_req = 1'b1; dma_addr = 16'h4000; dma_len = 4'd6;
        step();
        clear_reqs();
        step();
        stk_req = 1'b1; cpu_req = 1'b1;
        #2;
        rst = 1'b0;
        #1;
        chk("midrst_data", {RAMaddr, toRAM}, 32'd0);
        chk("midrst_ctl", {24'd0, w, stk_gnt, cpu_gnt, dma_gnt, stk_rvalid, cpu_rvalid,
                           dma_rvalid, dma_done}, 32'd0);
        clear_reqs();
        @(posedge clk);
        @(posedge clk);
        #1;
        rst = 1'b1;
        model_reset();
        cpu_req = 1'b1; cpu_w = 1'b0; cpu_addr = 16'h0010;
        step();
        idle(5);

        // Randomized traffic
        for (int i = 0; i < 3000; i++) begin
            drive_random();
            step();
        end
        idle(12);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/ram_port_arbiter.md
# ram_port_arbiter

Shares the single synchronous RAM port between three requesters: the stack unit, the CPU load/store path, and a read-only DMA burst engine (video/peripheral fetch). It sits between those requesters and the RAM and drives `RAMaddr`/`toRAM`/`w` from registers. A small state machine sequences DMA bursts. A starvation counter keeps back-to-back bursts from locking out the CPU.

## Interface
- `MAX_BURST`, 8: maximum DMA burst length in words; also the effective length when `dma_len` is 0.
- `STARVE_LIMIT`, 15: number of consecutive denied CPU-request cycles after which the CPU outranks a new DMA burst.
- `clk`  in  1  system clock; all state changes on its rising edge.
- `rst`  in  1  reset, asynchronous, active-low.
- `stk_req`, `stk_w`  in  1 each  stack access request and its write flag.
- `stk_addr`, `stk_wdata`  in  16 each  stack address and write data.
- `stk_gnt`  out  1  stack access accepted this cycle.
- `stk_rvalid`  out  1  `rdata` holds the stack read result.
- `cpu_req`, `cpu_w`, `cpu_addr`, `cpu_wdata`, `cpu_gnt`, `cpu_rvalid`: CPU port, same widths and meanings as the stack port.
- `dma_req`  in  1  burst request.
- `dma_addr`  in  16  burst start address.
- `dma_len`  in  4  burst length.
- `dma_gnt`  out  1  burst accepted.
- `dma_rvalid`  out  1  `rdata` holds a DMA word.
- `dma_done`  out  1  one-cycle pulse with the last DMA word.
- `fromRAM`  in  16  RAM read data, valid 1 cycle after the address.
- `rdata`  out  16  equals `fromRAM`, shared by all readers.
- `RAMaddr`  out  16  registered RAM address.
- `toRAM`  out  16  registered RAM write data.
- `w`  out  1  registered RAM write enable.

## Operation
- Requests are level signals. A requester holds `req` and its request fields stable until it sees `gnt`. `gnt` is combinational in the cycle the request is accepted. The requester drops or updates `req` in the following cycle.
- At most one `gnt` per cycle, with at most one RAM command issued per cycle.
- Priority in the IDLE state:
  - Stack first.
  - Then the CPU, if `starve_cnt == STARVE_LIMIT`.
  - Then DMA.
  - Then the CPU.
- State machine:
  - IDLE: no burst in progress. A DMA grant captures `dma_addr` into `burst_addr`, sets `burst_left = (dma_len==0 || dma_len>MAX_BURST) ? MAX_BURST : dma_len`, issues word 0 in the same cycle, and moves to BURST. If `burst_left` is 1, the state stays IDLE.
  - BURST: issues `burst_addr + i` (modulo 2^16, wraps 0xFFFF→0x0000), one word per cycle, and decrements `burst_left`. `stk_req` preempts for one cycle: the stack is granted, no DMA word is issued, and the burst resumes the next cycle. The CPU is never granted in BURST. When the last word is issued, the state returns to IDLE.
- Starvation counter `starve_cnt` (saturating, 0..`STARVE_LIMIT`):
  - Increments on each cycle with `cpu_req && !cpu_gnt`.
  - Clears on `cpu_gnt` and when `cpu_req` is low.
- Writes: `w` is 1 for exactly the cycle after the grant; `toRAM` equals the granted `wdata`. DMA never writes. On cycles with no command, `w=0`, `toRAM=0`, and `RAMaddr` holds its last value.
- Read return: a 2-stage owner pipeline (`owner`, `is_last`) carries each read grant.
  - `*_rvalid` pulses 2 cycles after the grant.
  - `dma_done` coincides with the `dma_rvalid` of the final burst word.
  - Write grants produce no `rvalid`.

## Timing
- Reset (`rst` low, any time): `RAMaddr=0`, `toRAM=0`, `w=0`, all `gnt`/`rvalid`/`dma_done`=0, state IDLE, `starve_cnt=0`, owner pipeline cleared. A burst in progress is abandoned with no `dma_done`.
- Grant in cycle t → `RAMaddr`/`w`/`toRAM` valid in t+1 → `fromRAM`/`rdata` and `rvalid` valid in t+2.
- Throughput: one access per cycle. An N-word burst with no stack interference occupies exactly N consecutive cycles.
- Simultaneous requests from all three in IDLE: the stack wins in t, then DMA in t+1 (unless the CPU is starved), and the CPU waits out the burst.
- `dma_req` arriving during BURST is ignored until IDLE. `dma_gnt` is asserted only on burst acceptance, never per word.

## Test plan
- Single CPU write 0x1234 @0x0010, then CPU read @0x0010 → `w=1` one cycle with `toRAM=0x1234`; `cpu_rvalid` 2 cycles after the read grant with `rdata=0x1234`.
- DMA `dma_addr=0xFFFE`, `dma_len=4` → addresses 0xFFFE, 0xFFFF, 0x0000, 0x0001 on consecutive cycles; 4 `dma_rvalid`; `dma_done` with the 4th.
- Burst of 8 with `stk_req` held 1 cycle at word 3 → the stack is granted that cycle; the burst takes 9 cycles with no word skipped or duplicated.
- `dma_req` held high continuously and `cpu_req` high → the CPU is granted at the first IDLE after `starve_cnt` reaches 15, before the next burst.
- `dma_len=0` → 8-word burst; `dma_len=1` → 1 word, `dma_done` on it, state stays IDLE.
- `rst` low during word 2 of a burst → all outputs 0 immediately; no `dma_done`; the first request after release is served from IDLE.
